sk6805_led_arbiter: RTL and testbench

- Shares the two-LED SK6805 chain between two requesters: req0 (high priority, e.g. recognition result) and req1 (low priority, e.g. status/heartbeat).
- Latches the winning request's colours and holds them for a programmed time in ms, with optional blinking, then falls back to IDLE_COLOR.
- Drives the six 8-bit colour inputs of the SK6805 serial driver, which streams them continuously.

---
 rtl/sk6805_led_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sk6805_led_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sk6805_led_arbiter.sv
// Two-requester arbiter for the SK6805 two-LED chain: latches the winning colours,
// holds them for a programmed number of ms with optional blinking, then returns to idle.
module sk6805_led_arbiter #(
  parameter int unsigned TICK_DIV   = 10000,
  parameter int unsigned BLINK_MS   = 250,
  parameter logic [23:0] IDLE_COLOR = 24'h000000
) (
  input  logic        clk_10MHz,
  input  logic        Rst,
  input  logic        req0_i,
  input  logic [23:0] color0_1_i,
  input  logic [23:0] color0_2_i,
  input  logic [15:0] hold0_i,
  input  logic        blink0_i,
  input  logic        req1_i,
  input  logic [23:0] color1_1_i,
  input  logic [23:0] color1_2_i,
  input  logic [15:0] hold1_i,
  input  logic        blink1_i,
  output logic        ack0_o,
  output logic        ack1_o,
  output logic        done0_o,
  output logic        done1_o,
  output logic [1:0]  owner_o,
  output logic [7:0]  R_Out1_o,
  output logic [7:0]  G_Out1_o,
  output logic [7:0]  B_Out1_o,
  output logic [7:0]  R_Out2_o,
  output logic [7:0]  G_Out2_o,
  output logic [7:0]  B_Out2_o
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_MS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHOW0 = 2'b01,
    SHOW1 = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic [PW-1:0] presc_q, presc_d;
  logic [15:0]   rem_q, rem_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          phase_q, phase_d;
  logic          blink_q, blink_d;
  logic [23:0]   cap1_q, cap1_d, cap2_q, cap2_d;
  logic [23:0]   rgb1_q, rgb1_d, rgb2_q, rgb2_d;
  logic          ack0_q, ack0_d, ack1_q, ack1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic [1:0]    owner_q, owner_d;

  logic accept0_c, accept1_c, tick_c, expire_c, toggle_c;

  assign accept0_c = req0_i;
  assign accept1_c = req1_i & ~req0_i & (state_q != SHOW0);
  assign tick_c    = (state_q != IDLE) && (presc_q == PRESC_MAX);
  // rem_q == 0 while showing means an indefinite hold, so it never reaches the expiry value.
  assign expire_c  = tick_c && (rem_q == 16'd1);
  assign toggle_c  = tick_c && blink_q && (bcnt_q == BLINK_MAX);

  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept0_c)      state_d = SHOW0;
    else if (accept1_c) state_d = SHOW1;
    else if (expire_c)  state_d = IDLE;
  end

  always_comb begin
    presc_d = presc_q;
    rem_d   = rem_q;
    bcnt_d  = bcnt_q;
    phase_d = phase_q;
    blink_d = blink_q;
    cap1_d  = cap1_q;
    cap2_d  = cap2_q;
    rgb1_d  = rgb1_q;
    rgb2_d  = rgb2_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    owner_d = 2'b00;
    case (state_d)
      SHOW0:   owner_d = 2'b01;
      SHOW1:   owner_d = 2'b10;
      default: owner_d = 2'b00;
    endcase

    if (accept0_c || accept1_c) begin
      ack0_d  = accept0_c;
      ack1_d  = ~accept0_c;
      cap1_d  = accept0_c ? color0_1_i : color1_1_i;
      cap2_d  = accept0_c ? color0_2_i : color1_2_i;
      blink_d = accept0_c ? blink0_i   : blink1_i;
      rem_d   = accept0_c ? hold0_i    : hold1_i;
      presc_d = '0;
      bcnt_d  = '0;
      phase_d = 1'b1;
      rgb1_d  = cap1_d;
      rgb2_d  = cap2_d;
    end else if (state_q != IDLE) begin
      presc_d = tick_c ? '0 : presc_q + PW'(1);
      if (tick_c) begin
        if (rem_q != 16'd0) rem_d = rem_q - 16'd1;
        bcnt_d = (bcnt_q == BLINK_MAX) ? '0 : bcnt_q + BW'(1);
      end
      if (expire_c) begin
        done0_d = (state_q == SHOW0);
        done1_d = (state_q == SHOW1);
        presc_d = '0;
        bcnt_d  = '0;
        rem_d   = 16'd0;
        phase_d = 1'b0;
        rgb1_d  = IDLE_COLOR;
        rgb2_d  = IDLE_COLOR;
      end else if (toggle_c) begin
        phase_d = ~phase_q;
        rgb1_d  = phase_q ? 24'h000000 : cap1_q;
        rgb2_d  = phase_q ? 24'h000000 : cap2_q;
      end
    end
  end

  always_ff @(posedge clk_10MHz or negedge Rst) begin
    if (!Rst) begin
      presc_q <= '0;
      rem_q   <= 16'd0;
      bcnt_q  <= '0;
      phase_q <= 1'b0;
      blink_q <= 1'b0;
      cap1_q  <= 24'h000000;
      cap2_q  <= 24'h000000;
      rgb1_q  <= IDLE_COLOR;
      rgb2_q  <= IDLE_COLOR;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      owner_q <= 2'b00;
    end else begin
      presc_q <= presc_d;
      rem_q   <= rem_d;
      bcnt_q  <= bcnt_d;
      phase_q <= phase_d;
      blink_q <= blink_d;
      cap1_q  <= cap1_d;
      cap2_q  <= cap2_d;
      rgb1_q  <= rgb1_d;
      rgb2_q  <= rgb2_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      owner_q <= owner_d;
    end
  end

  assign ack0_o   = ack0_q;
  assign ack1_o   = ack1_q;
  assign done0_o  = done0_q;
  assign done1_o  = done1_q;
  assign owner_o  = owner_q;
  assign R_Out1_o = rgb1_q[23:16];
  assign G_Out1_o = rgb1_q[15:8];
  assign B_Out1_o = rgb1_q[7:0];
  assign R_Out2_o = rgb2_q[23:16];
  assign G_Out2_o = rgb2_q[15:8];
  assign B_Out2_o = rgb2_q[7:0];

endmodule

// File: tb/tb_sk6805_led_arbiter.sv
// Scenario bench for sk6805_led_arbiter with a time-based reference model for random traffic.
module tb_sk6805_led_arbiter;

  localparam int unsigned TD = 10;
  localparam int unsigned BM = 2;

  logic        clk_10MHz = 1'b0;
  logic        Rst;
  logic        req0, req1, b0, b1;
  logic [23:0] c0_1, c0_2, c1_1, c1_2;
  logic [15:0] h0, h1;
  logic        ack0, ack1, done0, done1;
  logic [1:0]  owner;
  logic [7:0]  r1, g1, bl1, r2, g2, bl2;
  logic [47:0] rgb;

  int tests = 0;
  int fails = 0;

  assign rgb = {r1, g1, bl1, r2, g2, bl2};

  sk6805_led_arbiter #(.TICK_DIV(TD), .BLINK_MS(BM), .IDLE_COLOR(24'h000000)) dut (
    .clk_10MHz(clk_10MHz), .Rst(Rst),
    .req0_i(req0), .color0_1_i(c0_1), .color0_2_i(c0_2), .hold0_i(h0), .blink0_i(b0),
    .req1_i(req1), .color1_1_i(c1_1), .color1_2_i(c1_2), .hold1_i(h1), .blink1_i(b1),
    .ack0_o(ack0), .ack1_o(ack1), .done0_o(done0), .done1_o(done1), .owner_o(owner),
    .R_Out1_o(r1), .G_Out1_o(g1), .B_Out1_o(bl1), .R_Out2_o(r2), .G_Out2_o(g2), .B_Out2_o(bl2)
  );

  always #50 clk_10MHz = ~clk_10MHz;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic cyc1();
    @(posedge clk_10MHz);
    #1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; req0 = 0; req1 = 0; b0 = 0; b1 = 0;
    c0_1 = 0; c0_2 = 0; c1_1 = 0; c1_2 = 0; h0 = 0; h1 = 0;
    repeat (3) @(posedge clk_10MHz);
    #20 Rst = 1'b1;
    cyc1();
    tests++; if (owner !== 2'b00) begin fails++; $display("FAIL reset_owner: got %b want 00", owner); end
    tests++; if (rgb !== 48'h0) begin fails++; $display("FAIL reset_rgb: got %h want 0", rgb); end
    tests++; if ({ack0, ack1, done0, done1} !== 4'b0000) begin fails++; $display("FAIL reset_pulses: got %b want 0000", {ack0, ack1, done0, done1}); end
  endtask

  task automatic test_basic();
    int n;
    c0_1 = 24'hFF0000; c0_2 = 24'h00FF00; h0 = 16'd3; b0 = 0; req0 = 1;
    cyc1();
    tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL basic_ack: got %b want 1", ack0); end
    tests++; if (r1 !== 8'hFF || g2 !== 8'hFF || owner !== 2'b01) begin fails++; $display("FAIL basic_show: got R1=%h G2=%h owner=%b want FF FF 01", r1, g2, owner); end
    req0 = 0;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin cyc1(); n++; end
    tests++; if (n != 30) begin fails++; $display("FAIL basic_done_latency: got %0d want 30", n); end
    tests++; if (rgb !== 48'h0 || owner !== 2'b00) begin fails++; $display("FAIL basic_idle: got rgb=%h owner=%b want 0 00", rgb, owner); end
  endtask

  task automatic test_priority();
    int n;
    c0_1 = 24'h010203; c0_2 = 24'h040506; h0 = 16'd1; b0 = 0;
    c1_1 = 24'h0A0B0C; c1_2 = 24'h0D0E0F; h1 = 16'd2; b1 = 0;
    req0 = 1; req1 = 1;
    cyc1();
    tests++; if ({ack0, ack1} !== 2'b10) begin fails++; $display("FAIL prio_ack: got %b want 10", {ack0, ack1}); end
    req0 = 0;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      cyc1(); n++;
      if (ack1 !== 1'b0) begin tests++; fails++; $display("FAIL prio_pending_ack1: got 1 want 0"); end
    end
    tests++; if (n != 10) begin fails++; $display("FAIL prio_done0: got %0d want 10", n); end
    cyc1();
    tests++; if (ack1 !== 1'b1 || owner !== 2'b10) begin fails++; $display("FAIL prio_ack1: got ack1=%b owner=%b want 1 10", ack1, owner); end
    tests++; if (rgb !== {24'h0A0B0C, 24'h0D0E0F}) begin fails++; $display("FAIL prio_rgb1: got %h want 0a0b0c0d0e0f", rgb); end
    req1 = 0;
    n = 0;
    while (done1 !== 1'b1 && n < 40) begin cyc1(); n++; end
    tests++; if (n != 20) begin fails++; $display("FAIL prio_done1: got %0d want 20", n); end
  endtask

  task automatic test_indefinite();
    int bad, n;
    c1_1 = 24'h123456; c1_2 = 24'h654321; h1 = 16'd0; b1 = 0; req1 = 1;
    cyc1();
    tests++; if (ack1 !== 1'b1) begin fails++; $display("FAIL indef_ack1: got %b want 1", ack1); end
    req1 = 0;
    bad = 0;
    repeat (200) begin
      cyc1();
      if (done1 !== 1'b0 || owner !== 2'b10 || rgb !== {24'h123456, 24'h654321}) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL indef_hold: got %0d bad cycles want 0", bad); end
    c0_1 = 24'hABCDEF; c0_2 = 24'hFEDCBA; h0 = 16'd1; b0 = 0; req0 = 1;
    cyc1();
    tests++; if (ack0 !== 1'b1 || owner !== 2'b01 || done1 !== 1'b0) begin fails++; $display("FAIL indef_preempt: got ack0=%b owner=%b done1=%b want 1 01 0", ack0, owner, done1); end
    tests++; if (rgb !== {24'hABCDEF, 24'hFEDCBA}) begin fails++; $display("FAIL indef_preempt_rgb: got %h want abcdeffedcba", rgb); end
    req0 = 0;
    n = 0;
    while (done0 !== 1'b1 && n < 40) begin
      cyc1(); n++;
      if (done1 !== 1'b0) begin tests++; fails++; $display("FAIL indef_done1: got 1 want 0"); end
    end
    tests++; if (n != 10) begin fails++; $display("FAIL indef_done0: got %0d want 10", n); end
  endtask

  task automatic test_blink();
    logic [7:0] exp_b;
    c1_1 = 24'h0000FF; c1_2 = 24'h00FF00; h1 = 16'd8; b1 = 1; req1 = 1;
    cyc1();
    tests++; if (ack1 !== 1'b1 || bl1 !== 8'hFF) begin fails++; $display("FAIL blink_start: got ack1=%b B1=%h want 1 FF", ack1, bl1); end
    req1 = 0;
    for (int k = 1; k <= 80; k++) begin
      cyc1();
      exp_b = (k < 80 && ((k / 20) % 2) == 0) ? 8'hFF : 8'h00;
      tests++; if (bl1 !== exp_b) begin fails++; $display("FAIL blink_b1 k=%0d: got %h want %h", k, bl1, exp_b); end
      tests++; if (done1 !== (k == 80)) begin fails++; $display("FAIL blink_done1 k=%0d: got %b want %b", k, done1, k == 80); end
    end
    tests++; if (rgb !== 48'h0 || owner !== 2'b00) begin fails++; $display("FAIL blink_end: got rgb=%h owner=%b want 0 00", rgb, owner); end
    b1 = 0;
  endtask

  task automatic test_restart();
    c0_1 = 24'h00FFFF; c0_2 = 24'hFF00FF; h0 = 16'd5; b0 = 0; req0 = 1;
    cyc1();
    tests++; if (ack0 !== 1'b1) begin fails++; $display("FAIL restart_ack: got %b want 1", ack0); end
    for (int k = 1; k <= 76; k++) begin
      req0 = (k == 25);
      cyc1();
      tests++; if (ack0 !== (k == 25) || done0 !== (k == 75)) begin fails++; $display("FAIL restart k=%0d: got ack0=%b done0=%b want %b %b", k, ack0, done0, k == 25, k == 75); end
    end
    req0 = 0;
    tests++; if (owner !== 2'b00) begin fails++; $display("FAIL restart_idle: got %b want 00", owner); end
  endtask

  task automatic test_reset_mid();
    int bad;
    c1_1 = 24'hAABBCC; c1_2 = 24'h112233; h1 = 16'd4; b1 = 0; req1 = 1;
    cyc1();
    tests++; if (ack1 !== 1'b1 || owner !== 2'b10) begin fails++; $display("FAIL rstmid_ack: got ack1=%b owner=%b want 1 10", ack1, owner); end
    req1 = 0;
    repeat (15) cyc1();
    #20 Rst = 1'b0;
    #1;
    tests++; if (rgb !== 48'h0 || owner !== 2'b00 || done1 !== 1'b0) begin fails++; $display("FAIL rstmid_async: got rgb=%h owner=%b done1=%b want 0 00 0", rgb, owner, done1); end
    repeat (3) @(posedge clk_10MHz);
    #20 Rst = 1'b1;
    bad = 0;
    repeat (50) begin
      cyc1();
      if (owner !== 2'b00 || rgb !== 48'h0 || {ack0, ack1, done0, done1} !== 4'b0000) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_idle: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_random();
    int cyc, m_owner, m_start, m_hold;
    logic m_blink, a0, a1, e_d0, e_d1;
    logic [23:0] m_c1, m_c2;
    logic [47:0] e_rgb;
    cyc = 0; m_owner = 0; m_start = 0; m_hold = 0; m_blink = 0; m_c1 = 0; m_c2 = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!req0 && $urandom_range(0, 24) == 0) begin
        req0 = 1; c0_1 = 24'($urandom); c0_2 = 24'($urandom);
        h0 = 16'($urandom_range(0, 3)); b0 = 1'($urandom_range(0, 1));
      end
      if (!req1 && $urandom_range(0, 11) == 0) begin
        req1 = 1; c1_1 = 24'($urandom); c1_2 = 24'($urandom);
        h1 = 16'($urandom_range(0, 3)); b1 = 1'($urandom_range(0, 1));
      end
      a0 = req0;
      a1 = req1 && !req0 && (m_owner != 1);
      cyc1();
      cyc++;
      e_d0 = 0; e_d1 = 0;
      if (a0) begin
        m_owner = 1; m_start = cyc; m_hold = int'(h0); m_blink = b0; m_c1 = c0_1; m_c2 = c0_2;
      end else if (a1) begin
        m_owner = 2; m_start = cyc; m_hold = int'(h1); m_blink = b1; m_c1 = c1_1; m_c2 = c1_2;
      end else if (m_owner != 0 && m_hold != 0 && (cyc - m_start) == m_hold * int'(TD)) begin
        e_d0 = (m_owner == 1); e_d1 = (m_owner == 2); m_owner = 0;
      end
      if (m_owner == 0) e_rgb = 48'h0;
      else if (m_blink && (((cyc - m_start) / int'(BM * TD)) % 2) == 1) e_rgb = 48'h0;
      else e_rgb = {m_c1, m_c2};
      tests++;
      if ({ack0, ack1, done0, done1} !== {a0, a1, e_d0, e_d1} || owner !== 2'(m_owner) || rgb !== e_rgb) begin
        fails++;
        $display("FAIL random cyc=%0d: got ack=%b%b done=%b%b owner=%b rgb=%h want ack=%b%b done=%b%b owner=%b rgb=%h",
                 cyc, ack0, ack1, done0, done1, owner, rgb, a0, a1, e_d0, e_d1, 2'(m_owner), e_rgb);
      end
      if (a0) req0 = 0;
      if (a1) req1 = 0;
    end
    req0 = 0; req1 = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_indefinite();
    test_blink();
    test_restart();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
